// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan observer.
package seg7_pkg;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ERR_CODE   = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder with an invalid flag.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       invalid
);

    // Table lookup; an all-off pattern is a legal blank, not an error
    always_comb begin
        bcd     = ERR_CODE;
        invalid = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BLANK_CODE;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observer for the multiplexed 7-segment bus: synchronises the pads, waits
// for the scan to settle on each digit and rebuilds the three BCD digits.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [2:0]  digit_sel_in,
    output logic [11:0] digits_out,
    output logic [2:0]  digit_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic        sel_err,
    output logic        stale
);

    // Pad level meaning "nothing driven"; XOR with it normalises to active-high
    localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] SEL_IDLE = SEL_ACTIVE_LOW ? 3'h7 : 3'h0;

    logic [6:0]      seg_s1, seg_s2, seg_n;
    logic [2:0]      sel_s1, sel_s2, sel_n;
    logic            stable, settled;
    logic [7:0]      stab_cnt;
    scan_state_t     state, state_nxt;
    logic            evaluate, capture, sel_bad;
    logic [3:0]      dec_bcd;
    logic            dec_invalid;
    logic [2:0][3:0] digit_q;
    logic [2:0]      frame_mask, mask_upd;
    logic [15:0]     tmo_cnt, tmo_nxt;

    // Two-flop synchroniser; reset to the idle pad level so a cleared chain reads as "no digit"
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1 <= SEG_IDLE;
            seg_s2 <= SEG_IDLE;
            sel_s1 <= SEL_IDLE;
            sel_s2 <= SEL_IDLE;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            sel_s1 <= digit_sel_in;
            sel_s2 <= sel_s1;
        end
    end

    assign seg_n = seg_s2 ^ SEG_IDLE;
    assign sel_n = sel_s2 ^ SEL_IDLE;

    // The synchronised value holds into the next cycle when both stages agree
    assign stable  = (seg_s1 == seg_s2) && (sel_s1 == sel_s2);
    assign settled = stable && (({1'b0, stab_cnt} + 9'd1) >= 9'(SETTLE_CYCLES));

    // Stability counter: run length of unchanged synchronised inputs, saturating
    always_ff @(posedge clk) begin
        if (rst || !stable)
            stab_cnt <= 8'd0;
        else if (stab_cnt != 8'hFF)
            stab_cnt <= stab_cnt + 8'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; IDLE may evaluate directly when the settle window is a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_n != 3'b000) state_nxt = settled ? HOLD : SETTLE;
            SETTLE:  if (sel_n == 3'b000) state_nxt = IDLE;
                     else if (settled)    state_nxt = HOLD;
            HOLD:    if (!stable)         state_nxt = SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: evaluate a settled, non-zero select exactly once per scan step
    always_comb begin
        evaluate = (state != HOLD) && (sel_n != 3'b000) && settled;
        capture  = evaluate && is_onehot3(sel_n);
        sel_bad  = evaluate && !is_onehot3(sel_n);
    end

    seg7_to_bcd u_dec (
        .seg     (seg_n),
        .bcd     (dec_bcd),
        .invalid (dec_invalid)
    );

    assign mask_upd = frame_mask | sel_n;

    // Digit registers, frame tracking and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q     <= '0;
            digit_valid <= 3'b000;
            frame_mask  <= 3'b000;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (capture) begin
                for (int i = 0; i < 3; i++)
                    if (sel_n[i]) digit_q[i] <= dec_bcd;
                digit_valid <= digit_valid | sel_n;
                pattern_err <= pattern_err | dec_invalid;
                if (mask_upd == 3'b111) begin
                    frame_done <= 1'b1;
                    frame_mask <= 3'b000;
                end else begin
                    frame_mask <= mask_upd;
                end
            end else if (sel_bad) begin
                sel_err    <= 1'b1;
                frame_mask <= 3'b000;
            end
        end
    end

    assign digits_out = digit_q;

    // Next value of the capture-age counter; restarts on the capture edge itself
    always_comb begin
        if (capture)                tmo_nxt = 16'd0;
        else if (tmo_cnt != 16'hFFFF) tmo_nxt = tmo_cnt + 16'd1;
        else                        tmo_nxt = tmo_cnt;
    end

    // Capture-age counter and stale flag, flag derived from the next count so it drops with the capture
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 16'd0;
            stale   <= 1'b0;
        end else begin
            tmo_cnt <= tmo_nxt;
            stale   <= (tmo_nxt >= 16'(TIMEOUT_CYCLES));
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: directed scenarios plus randomized scan sequences
// compared against a digit-level reference model.
module tb_seg7_scan_decoder;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h00;
    logic [2:0]  sel = 3'b000;
    logic [11:0] digits, digits_n;
    logic [2:0]  valid, valid_n;
    logic        fd, fd_n, perr, perr_n, serr, serr_n, stale, stale_n;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO),
                        .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .seg_in(seg), .digit_sel_in(sel),
        .digits_out(digits), .digit_valid(valid), .frame_done(fd),
        .pattern_err(perr), .sel_err(serr), .stale(stale));

    // Same scan driven at inverted pad polarity
    seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO),
                        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .seg_in(~seg), .digit_sel_in(~sel),
        .digits_out(digits_n), .digit_valid(valid_n), .frame_done(fd_n),
        .pattern_err(perr_n), .sel_err(serr_n), .stale(stale_n));

    int edge_cnt = 0;
    int fd_cnt   = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(posedge clk) if (fd) fd_cnt <= fd_cnt + 1;

    // Reference model state
    logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0] exp_dig [3];
    logic [2:0] exp_valid, exp_mask;
    logic       exp_perr, exp_serr;
    int         exp_frames, last_cap, fd0;
    int         n_checks = 0;
    int         n_pass   = 0;

    // {bad, nibble} for a segment pattern
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return {1'b0, 4'hF};
        for (int i = 0; i < 10; i++)
            if (PAT[i] == p) return {1'b0, 4'(i)};
        return {1'b1, 4'hE};
    endfunction

    function automatic logic [11:0] exp_digits();
        return {exp_dig[2], exp_dig[1], exp_dig[0]};
    endfunction

    function automatic logic exp_stale();
        return (edge_cnt - last_cap) >= TMO;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) exp_dig[i] = 4'h0;
        exp_valid  = 3'b000;
        exp_mask   = 3'b000;
        exp_perr   = 1'b0;
        exp_serr   = 1'b0;
        exp_frames = 0;
        last_cap   = edge_cnt;
        fd0        = fd_cnt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel = 3'b000;
        seg = 7'h00;
        step(2);
        rst = 1'b0;
        model_reset();
    endtask

    // Effect of one settled scan step on the displayed state
    task automatic model_capture(input logic [2:0] s, input logic [6:0] p, input int cap_edge);
        logic [4:0] d;
        if ($countones(s) != 1) begin
            exp_serr = 1'b1;
            exp_mask = 3'b000;
        end else begin
            d = ref_decode(p);
            for (int i = 0; i < 3; i++) if (s[i]) exp_dig[i] = d[3:0];
            exp_valid = exp_valid | s;
            exp_perr  = exp_perr | d[4];
            exp_mask  = exp_mask | s;
            if (exp_mask == 3'b111) begin
                exp_frames++;
                exp_mask = 3'b000;
            end
            last_cap = cap_edge;
        end
    endtask

    task automatic hold_item(input logic [2:0] s, input logic [6:0] p, input int n);
        int e;
        sel = s;
        seg = p;
        e = edge_cnt;
        step(n);
        model_capture(s, p, e + 6);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({digits, valid, fd, perr, serr, stale} !== 18'd0)
            $display("FAIL reset_dut: got %h want 0", {digits, valid, fd, perr, serr, stale}); else n_pass++;
        n_checks++; if ({digits_n, valid_n, fd_n, perr_n, serr_n, stale_n} !== 18'd0)
            $display("FAIL reset_dut_n: got %h want 0", {digits_n, valid_n, fd_n, perr_n, serr_n, stale_n}); else n_pass++;
    endtask

    task automatic test_frame();
        do_reset();
        sel = 3'b001;
        seg = 7'h06;
        step(5);
        n_checks++; if ({digits, valid} !== 15'd0)
            $display("FAIL frame_early: got %h/%b want 000/000", digits, valid); else n_pass++;
        step(1);
        model_capture(3'b001, 7'h06, edge_cnt);
        n_checks++; if (digits !== 12'h001 || valid !== 3'b001)
            $display("FAIL frame_latency: got %h/%b want 001/001", digits, valid); else n_pass++;
        step(4);
        hold_item(3'b010, 7'h5B, 10);
        hold_item(3'b100, 7'h4F, 10);
        n_checks++; if (digits !== 12'h321)
            $display("FAIL frame_digits: got %h want 321", digits); else n_pass++;
        n_checks++; if (valid !== 3'b111)
            $display("FAIL frame_valid: got %b want 111", valid); else n_pass++;
        n_checks++; if (fd_cnt - fd0 !== 1)
            $display("FAIL frame_pulses: got %0d want 1", fd_cnt - fd0); else n_pass++;
        n_checks++; if ({perr, serr, stale} !== 3'b000)
            $display("FAIL frame_flags: got %b want 000", {perr, serr, stale}); else n_pass++;
    endtask

    task automatic test_no_settle();
        do_reset();
        sel = 3'b001;
        seg = 7'h06;
        for (int i = 0; i < 10; i++) begin
            step(3);
            seg = (i % 2 == 0) ? 7'h5B : 7'h06;
        end
        n_checks++; if (valid !== 3'b000 || digits !== 12'h000)
            $display("FAIL nosettle_capture: got %b/%h want 000/000", valid, digits); else n_pass++;
        n_checks++; if (stale !== exp_stale())
            $display("FAIL nosettle_stale: got %b want %b", stale, exp_stale()); else n_pass++;
    endtask

    task automatic test_pattern_err();
        do_reset();
        hold_item(3'b001, 7'h55, 10);
        n_checks++; if (digits !== 12'h00E || perr !== 1'b1 || valid !== 3'b001)
            $display("FAIL perr_capture: got %h/%b/%b want 00E/1/001", digits, perr, valid); else n_pass++;
        hold_item(3'b010, 7'h06, 10);
        n_checks++; if (perr !== 1'b1 || digits !== 12'h01E)
            $display("FAIL perr_sticky: got %b/%h want 1/01E", perr, digits); else n_pass++;
    endtask

    task automatic test_sel_err();
        do_reset();
        hold_item(3'b001, 7'h06, 10);
        hold_item(3'b011, 7'h06, 10);
        n_checks++; if (serr !== 1'b1 || digits !== 12'h001)
            $display("FAIL selerr_flag: got %b/%h want 1/001", serr, digits); else n_pass++;
        hold_item(3'b010, 7'h5B, 10);
        hold_item(3'b100, 7'h4F, 10);
        n_checks++; if (fd_cnt - fd0 !== 0)
            $display("FAIL selerr_mask_cleared: got %0d pulses want 0", fd_cnt - fd0); else n_pass++;
        hold_item(3'b001, 7'h3F, 10);
        n_checks++; if (fd_cnt - fd0 !== 1 || digits !== 12'h320 || serr !== 1'b1)
            $display("FAIL selerr_next_frame: got %0d/%h/%b want 1/320/1", fd_cnt - fd0, digits, serr); else n_pass++;
    endtask

    task automatic test_stale();
        do_reset();
        step(TMO - 1);
        n_checks++; if (stale !== 1'b0)
            $display("FAIL stale_early: got %b want 0", stale); else n_pass++;
        step(1);
        n_checks++; if (stale !== 1'b1)
            $display("FAIL stale_assert: got %b want 1", stale); else n_pass++;
        sel = 3'b001;
        seg = 7'h7F;
        step(5);
        n_checks++; if (stale !== 1'b1)
            $display("FAIL stale_before_capture: got %b want 1", stale); else n_pass++;
        step(1);
        n_checks++; if (stale !== 1'b0 || digits !== 12'h008)
            $display("FAIL stale_drop: got %b/%h want 0/008", stale, digits); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] s, ps;
        logic [6:0] p, pp;
        int r;
        do_reset();
        ps = 3'b000;
        pp = 7'h00;
        for (int k = 0; k < 40; k++) begin
            do begin
                if ($urandom_range(0, 7) == 0) begin
                    do s = 3'($urandom_range(1, 7)); while ($countones(s) == 1);
                end else begin
                    s = 3'b001 << $urandom_range(0, 2);
                end
                r = $urandom_range(0, 11);
                if (r < 10)       p = PAT[r];
                else if (r == 10) p = 7'h00;
                else begin
                    do p = 7'($urandom_range(1, 127)); while (ref_decode(p) != 5'h1E);
                end
            end while (s == ps && p == pp);
            hold_item(s, p, $urandom_range(7, 12));
            ps = s;
            pp = p;
            n_checks++; if (digits !== exp_digits() || valid !== exp_valid)
                $display("FAIL rand_digits[%0d]: got %h/%b want %h/%b", k, digits, valid, exp_digits(), exp_valid); else n_pass++;
            n_checks++; if (perr !== exp_perr || serr !== exp_serr || stale !== exp_stale())
                $display("FAIL rand_flags[%0d]: got %b%b%b want %b%b%b", k, perr, serr, stale, exp_perr, exp_serr, exp_stale()); else n_pass++;
            n_checks++; if (digits_n !== exp_digits() || valid_n !== exp_valid || perr_n !== exp_perr || serr_n !== exp_serr)
                $display("FAIL rand_activelow[%0d]: got %h/%b/%b%b want %h/%b/%b%b", k, digits_n, valid_n, perr_n, serr_n, exp_digits(), exp_valid, exp_perr, exp_serr); else n_pass++;
        end
        n_checks++; if (fd_cnt - fd0 !== exp_frames)
            $display("FAIL rand_frames: got %0d want %0d", fd_cnt - fd0, exp_frames); else n_pass++;
    endtask

    task automatic test_reset_mid();
        sel = (sel == 3'b010) ? 3'b100 : 3'b010;
        seg = 7'h07;
        step(3);
        rst = 1'b1;
        sel = 3'b000;
        seg = 7'h00;
        step(1);
        rst = 1'b0;
        model_reset();
        n_checks++; if ({digits, valid, fd, perr, serr, stale} !== 18'd0)
            $display("FAIL midreset_outputs: got %h want 0", {digits, valid, fd, perr, serr, stale}); else n_pass++;
        n_checks++; if ({digits_n, valid_n, fd_n, perr_n, serr_n, stale_n} !== 18'd0)
            $display("FAIL midreset_outputs_n: got %h want 0", {digits_n, valid_n, fd_n, perr_n, serr_n, stale_n}); else n_pass++;
        step(10);
        n_checks++; if (valid !== 3'b000 || digits !== 12'h000)
            $display("FAIL midreset_no_capture: got %b/%h want 000/000", valid, digits); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_settle();
        test_pattern_err();
        test_sel_err();
        test_stale();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
